// File: rtl/sram_port_arbiter.sv
// Single-port SRAM arbiter between instruction fetch and MEM load/store, with data priority and a fetch anti-starvation counter.
// Optional build macro ARB_PERF_EN adds the free-running conflict and forced-grant counters.
module sram_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_rvalid,
  output logic [31:0]       inst_rdata,
  input  logic              data_req,
  input  logic [3:0]        data_wen,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_wdata,
  output logic              data_rvalid,
  output logic [31:0]       data_rdata,
  output logic              sram_en,
  output logic [3:0]        sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata,
  output logic              stallreq_if,
  output logic              stallreq_mem
`ifdef ARB_PERF_EN
  ,
  output logic [31:0]       perf_conflict_cnt,
  output logic [31:0]       perf_force_cnt
`endif
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } owner_e;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  owner_e     owner_q, owner_d;
  logic [3:0] starve_q, starve_d;
  logic       was_load_q, was_load_d;

  logic       force_w;
  logic       data_gnt;
  logic       inst_gnt;

  // Issue stage: grant decision and SRAM command
  assign force_w  = inst_req & (starve_q == STARVE_LIM);
  assign data_gnt = ~rst & data_req & ~force_w;
  assign inst_gnt = ~rst & inst_req & ~data_gnt;

  assign stallreq_if  = inst_req & ~inst_gnt;
  assign stallreq_mem = data_req & ~data_gnt;

  always_comb begin
    sram_en    = 1'b0;
    sram_wen   = 4'b0000;
    sram_addr  = '0;
    sram_wdata = '0;
    if (data_gnt) begin
      sram_en    = 1'b1;
      sram_wen   = data_wen;
      sram_addr  = data_addr;
      sram_wdata = data_wdata;
    end else if (inst_gnt) begin
      sram_en    = 1'b1;
      sram_addr  = inst_addr;
    end
  end

  always_comb begin
    owner_d    = OWN_NONE;
    was_load_d = was_load_q;
    starve_d   = 4'd0;
    if (data_gnt) begin
      owner_d    = OWN_DATA;
      was_load_d = ~|data_wen;
    end else if (inst_gnt) begin
      owner_d    = OWN_INST;
    end
    if (inst_req & ~inst_gnt) begin
      starve_d = sat_inc4(starve_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q    <= OWN_NONE;
      starve_q   <= 4'd0;
      was_load_q <= 1'b0;
    end else begin
      owner_q    <= owner_d;
      starve_q   <= starve_d;
      was_load_q <= was_load_d;
    end
  end

  // Response stage: route SRAM read data to whoever issued last cycle
  always_comb begin
    inst_rvalid = 1'b0;
    inst_rdata  = '0;
    data_rvalid = 1'b0;
    data_rdata  = '0;
    if (!rst) begin
      if (owner_q == OWN_INST) begin
        inst_rvalid = 1'b1;
        inst_rdata  = sram_rdata;
      end else if (owner_q == OWN_DATA) begin
        data_rvalid = 1'b1;
        if (was_load_q) begin
          data_rdata = sram_rdata;
        end
      end
    end
  end

`ifdef ARB_PERF_EN
  logic [31:0] conflict_q, conflict_d;
  logic [31:0] force_cnt_q, force_cnt_d;

  always_comb begin
    conflict_d  = conflict_q;
    force_cnt_d = force_cnt_q;
    if (inst_req & data_req) begin
      conflict_d = conflict_q + 32'd1;
    end
    if (force_w) begin
      force_cnt_d = force_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_q  <= '0;
      force_cnt_q <= '0;
    end else begin
      conflict_q  <= conflict_d;
      force_cnt_q <= force_cnt_d;
    end
  end

  assign perf_conflict_cnt = conflict_q;
  assign perf_force_cnt    = force_cnt_q;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed plus randomized bench for sram_port_arbiter against a cycle-level reference model.
module tb_sram_port_arbiter;

  localparam int ADDR_W     = 32;
  localparam int STARVE_MAX = 4;

  logic              clk;
  logic              rst;
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_rvalid;
  logic [31:0]       inst_rdata;
  logic              data_req;
  logic [3:0]        data_wen;
  logic [ADDR_W-1:0] data_addr;
  logic [31:0]       data_wdata;
  logic              data_rvalid;
  logic [31:0]       data_rdata;
  logic              sram_en;
  logic [3:0]        sram_wen;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_wdata;
  logic [31:0]       sram_rdata;
  logic              stallreq_if;
  logic              stallreq_mem;

  sram_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rvalid(data_rvalid), .data_rdata(data_rdata),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata),
    .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: fetch-denial streak and the access issued in the previous cycle
  // (0 none, 1 fetch, 2 load, 3 store).
  int m_denied = 0;
  int m_resp   = 0;
  bit cur_ig   = 0;
  bit cur_dg   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    bit frc;
    logic [31:0] e_addr, e_wdata, e_ird, e_drd;
    logic [3:0]  e_wen;
    bit e_irv, e_drv;
    #3;
    if (rst) begin
      cur_ig = 0;
      cur_dg = 0;
    end else begin
      frc    = inst_req && (m_denied == STARVE_MAX);
      cur_dg = data_req && !frc;
      cur_ig = inst_req && !cur_dg;
    end
    e_wen   = cur_dg ? data_wen : 4'b0000;
    e_addr  = cur_dg ? data_addr : (cur_ig ? inst_addr : 32'h0);
    e_wdata = cur_dg ? data_wdata : 32'h0;
    e_irv   = !rst && (m_resp == 1);
    e_drv   = !rst && (m_resp >= 2);
    e_ird   = e_irv ? sram_rdata : 32'h0;
    e_drd   = (!rst && m_resp == 2) ? sram_rdata : 32'h0;
    chk("sram_en",      sram_en,      cur_ig || cur_dg);
    chk("sram_wen",     sram_wen,     e_wen);
    chk("sram_addr",    sram_addr,    e_addr);
    chk("sram_wdata",   sram_wdata,   e_wdata);
    chk("stallreq_if",  stallreq_if,  inst_req && !cur_ig);
    chk("stallreq_mem", stallreq_mem, data_req && !cur_dg);
    chk("inst_rvalid",  inst_rvalid,  e_irv);
    chk("inst_rdata",   inst_rdata,   e_ird);
    chk("data_rvalid",  data_rvalid,  e_drv);
    chk("data_rdata",   data_rdata,   e_drd);
  endtask

  task automatic advance();
    if (rst) begin
      m_denied = 0;
      m_resp   = 0;
    end else begin
      m_resp   = cur_dg ? ((data_wen == 4'b0000) ? 2 : 3) : (cur_ig ? 1 : 0);
      m_denied = (inst_req && !cur_ig) ? ((m_denied < 15) ? m_denied + 1 : 15) : 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_req   = 1'b0;
    data_req   = 1'b0;
    data_wen   = 4'b0000;
    inst_addr  = '0;
    data_addr  = '0;
    data_wdata = '0;
  endtask

  initial begin
    bit hold_i, hold_d;
    rst = 1'b1;
    idle_inputs();
    sram_rdata = 32'h0;
    @(posedge clk);
    #1;

    // Reset with both requesters active, then release: data wins
    inst_req  = 1'b1; inst_addr = 32'h0000_0010;
    data_req  = 1'b1; data_addr = 32'h0000_0020; data_wdata = 32'h5555_AAAA;
    settle();
    chk("t1_rst_en",       sram_en, 1'b0);
    chk("t1_rst_stall_if", stallreq_if, 1'b1);
    chk("t1_rst_stall_mem", stallreq_mem, 1'b1);
    advance();
    rst = 1'b0;
    settle();
    chk("t1_rel_addr", sram_addr, 32'h0000_0020);
    chk("t1_rel_stall_mem", stallreq_mem, 1'b0);
    advance();
    idle_inputs();
    settle();
    advance();

    // Lone fetch
    inst_req = 1'b1; inst_addr = 32'h0000_0100;
    settle();
    chk("t2_addr", sram_addr, 32'h0000_0100);
    chk("t2_stall_if", stallreq_if, 1'b0);
    advance();
    inst_req = 1'b0;
    sram_rdata = 32'hDEAD_BEEF;
    settle();
    chk("t2_rvalid", inst_rvalid, 1'b1);
    chk("t2_rdata", inst_rdata, 32'hDEAD_BEEF);
    advance();

    // Partial store is acked with zero read data
    data_req = 1'b1; data_wen = 4'b0011; data_addr = 32'h0000_0040; data_wdata = 32'h0000_1234;
    settle();
    chk("t3_wen", sram_wen, 4'b0011);
    chk("t3_wdata", sram_wdata, 32'h0000_1234);
    advance();
    idle_inputs();
    sram_rdata = 32'hA5A5_5A5A;
    settle();
    chk("t3_ack", data_rvalid, 1'b1);
    chk("t3_rdata", data_rdata, 32'h0);
    advance();

    // Sustained contention: fetch forced in on the fifth cycle
    for (int i = 0; i < 6; i++) begin
      inst_req = 1'b1; inst_addr = 32'h0000_0200;
      data_req = 1'b1; data_addr = 32'h0000_0300; data_wen = 4'b0000;
      sram_rdata = $urandom;
      settle();
      chk("t4_addr", sram_addr, (i == 4) ? 32'h0000_0200 : 32'h0000_0300);
      chk("t4_stall_mem", stallreq_mem, (i == 4) ? 1'b1 : 1'b0);
      advance();
    end
    idle_inputs();
    sram_rdata = $urandom;
    settle();
    advance();

    // Alternating owners
    for (int k = 0; k < 8; k++) begin
      idle_inputs();
      data_req  = (k % 2 == 0);
      data_addr = 32'h0000_1000 + 32'(k);
      inst_req  = (k % 2 == 1);
      inst_addr = 32'h0000_2000 + 32'(k);
      sram_rdata = $urandom;
      settle();
      if (k > 0) begin
        chk("t5_drv", data_rvalid, (k % 2 == 1));
        chk("t5_irv", inst_rvalid, (k % 2 == 0));
      end
      advance();
    end

    // Reset right after a load drops its response and clears the starvation count
    idle_inputs();
    data_req = 1'b1; data_addr = 32'h0000_0080;
    settle();
    advance();
    idle_inputs();
    rst = 1'b1;
    sram_rdata = 32'hCAFE_F00D;
    settle();
    chk("t6_rst_drv", data_rvalid, 1'b0);
    advance();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      inst_req = 1'b1; inst_addr = 32'h0000_0400;
      data_req = 1'b1; data_addr = 32'h0000_0500;
      settle();
      if (i == 0) chk("t6_post_drv", data_rvalid, 1'b0);
      chk("t6_stall_mem", stallreq_mem, (i == 4) ? 1'b1 : 1'b0);
      advance();
    end
    idle_inputs();
    settle();
    advance();

    // Randomized traffic; requesters hold while stalled
    for (int n = 0; n < 400; n++) begin
      hold_i = inst_req && !cur_ig;
      hold_d = data_req && !cur_dg;
      rst = ($urandom_range(0, 99) == 0);
      if (!hold_i) begin
        inst_req  = ($urandom_range(0, 3) != 0);
        inst_addr = $urandom;
      end
      if (!hold_d) begin
        data_req   = ($urandom_range(0, 2) != 0);
        data_addr  = $urandom;
        data_wdata = $urandom;
        data_wen   = $urandom_range(0, 1) ? 4'b0000 : 4'($urandom_range(1, 15));
      end
      sram_rdata = $urandom;
      settle();
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
